// File: rtl/urv_rf_wb_arbiter_pkg.sv
// Shared constants and helpers for the register-file write-port arbiter.
package urv_rf_wb_arbiter_pkg;

  localparam int URV_NREGS = 32;
  localparam int URV_XLEN  = 32;
  localparam int URV_RIDX  = 5;

  // Source that owns the register-file write port in a given cycle.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_PIPE = 2'd1,
    SRC_BUF  = 2'd2,
    SRC_DBG  = 2'd3
  } wb_src_e;

  // One-hot mask over x1..x31; x0 never maps to a bit.
  function automatic logic [URV_NREGS-1:1] reg_mask(input logic [URV_RIDX-1:0] idx);
    logic [URV_NREGS-1:1] mask;
    mask = '0;
    for (int i = 1; i < URV_NREGS; i++) begin
      mask[i] = (idx == i[URV_RIDX-1:0]);
    end
    return mask;
  endfunction

endpackage

// File: rtl/urv_rr_arb2.sv
// Two-way round-robin arbiter. The pointer favours the requester that was
// not granted most recently; after reset it favours requester 0.
module urv_rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic ptr_q;

  // Grant decision: a lone requester always wins, a tie follows the pointer.
  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (req_i[0] && (!req_i[1] || !ptr_q)) begin
        gnt_o[0] = 1'b1;
      end else if (req_i[1]) begin
        gnt_o[1] = 1'b1;
      end
    end
  end

  // Pointer moves to the other requester whenever a grant is issued.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ptr_q <= 1'b0;
    end else if (|gnt_o) begin
      ptr_q <= gnt_o[0];
    end
  end

endmodule

// File: rtl/urv_rf_wb_arbiter.sv
// Register-file write-port arbiter with long-latency skid buffer and
// pending-register scoreboard driving the decode stall.
module urv_rf_wb_arbiter
  import urv_rf_wb_arbiter_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [URV_RIDX-1:0] w_rd_i,
  input  logic [URV_XLEN-1:0] w_rd_value_i,
  input  logic                w_rd_store_i,
  input  logic                lu_issue_i,
  input  logic [URV_RIDX-1:0] lu_issue_rd_i,
  input  logic                lu_valid_i,
  input  logic [URV_RIDX-1:0] lu_rd_i,
  input  logic [URV_XLEN-1:0] lu_value_i,
  output logic                lu_ready_o,
  input  logic                dbg_valid_i,
  input  logic [URV_RIDX-1:0] dbg_rd_i,
  input  logic [URV_XLEN-1:0] dbg_value_i,
  output logic                dbg_ready_o,
  input  logic                d_valid_i,
  input  logic [URV_RIDX-1:0] d_rs1_i,
  input  logic [URV_RIDX-1:0] d_rs2_i,
  input  logic [URV_RIDX-1:0] d_rd_i,
  output logic                hazard_stall_o,
  output logic [URV_RIDX-1:0] rf_rd_o,
  output logic [URV_XLEN-1:0] rf_rd_value_o,
  output logic                rf_rd_store_o
);

  logic                 buf_valid_q;
  logic [URV_RIDX-1:0]  buf_rd_q;
  logic [URV_XLEN-1:0]  buf_value_q;
  logic [URV_NREGS-1:1] pending_q;
  logic [URV_NREGS-1:0] pending_vec;
  logic [1:0]           arb_gnt;
  logic                 buf_gnt;
  wb_src_e              win_src;
  logic [URV_RIDX-1:0]  win_rd;
  logic [URV_XLEN-1:0]  win_value;

  // Buffer is granted only when the pipeline is idle; the arbiter is gated off
  // so its pointer is untouched by pipeline cycles.
  urv_rr_arb2 u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (!w_rd_store_i),
    .req_i ({dbg_valid_i, buf_valid_q}),
    .gnt_o (arb_gnt)
  );

  assign buf_gnt     = arb_gnt[0];
  assign dbg_ready_o = arb_gnt[1];
  assign lu_ready_o  = !buf_valid_q;

  // Winner selection: pipeline first, then whichever the arbiter granted.
  always_comb begin
    win_src   = SRC_NONE;
    win_rd    = w_rd_i;
    win_value = w_rd_value_i;
    if (w_rd_store_i) begin
      win_src = SRC_PIPE;
    end else if (buf_gnt) begin
      win_src = SRC_BUF;
    end else if (dbg_ready_o) begin
      win_src = SRC_DBG;
    end
    case (win_src)
      SRC_BUF: begin
        win_rd    = buf_rd_q;
        win_value = buf_value_q;
      end
      SRC_DBG: begin
        win_rd    = dbg_rd_i;
        win_value = dbg_value_i;
      end
      default: begin
        win_rd    = w_rd_i;
        win_value = w_rd_value_i;
      end
    endcase
  end

  // Skid buffer: capture when empty, free on the edge it is granted.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      buf_valid_q <= 1'b0;
      buf_rd_q    <= '0;
      buf_value_q <= '0;
    end else if (lu_valid_i && lu_ready_o) begin
      buf_valid_q <= 1'b1;
      buf_rd_q    <= lu_rd_i;
      buf_value_q <= lu_value_i;
    end else if (buf_gnt) begin
      buf_valid_q <= 1'b0;
    end
  end

  // Register the winner; x0 writes are consumed but never enable the write.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rf_rd_o       <= '0;
      rf_rd_value_o <= '0;
      rf_rd_store_o <= 1'b0;
    end else if (win_src != SRC_NONE) begin
      rf_rd_o       <= win_rd;
      rf_rd_value_o <= win_value;
      rf_rd_store_o <= (win_rd != '0);
    end else begin
      rf_rd_store_o <= 1'b0;
    end
  end

  // Scoreboard: a re-issue on the clearing edge keeps the register pending.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pending_q <= '0;
    end else begin
      pending_q <= (pending_q & ~(buf_gnt ? reg_mask(buf_rd_q) : '0))
                 | (lu_issue_i ? reg_mask(lu_issue_rd_i) : '0);
    end
  end

  assign pending_vec    = {pending_q, 1'b0};
  assign hazard_stall_o = d_valid_i && (pending_vec[d_rs1_i] || pending_vec[d_rs2_i]
                                        || pending_vec[d_rd_i]);

endmodule

// File: tb/tb_urv_rf_wb_arbiter.sv
// Directed bench for urv_rf_wb_arbiter with hand-computed expectations.
module tb_urv_rf_wb_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [4:0]  w_rd_i;
  logic [31:0] w_rd_value_i;
  logic        w_rd_store_i;
  logic        lu_issue_i;
  logic [4:0]  lu_issue_rd_i;
  logic        lu_valid_i;
  logic [4:0]  lu_rd_i;
  logic [31:0] lu_value_i;
  logic        lu_ready_o;
  logic        dbg_valid_i;
  logic [4:0]  dbg_rd_i;
  logic [31:0] dbg_value_i;
  logic        dbg_ready_o;
  logic        d_valid_i;
  logic [4:0]  d_rs1_i, d_rs2_i, d_rd_i;
  logic        hazard_stall_o;
  logic [4:0]  rf_rd_o;
  logic [31:0] rf_rd_value_o;
  logic        rf_rd_store_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  urv_rf_wb_arbiter dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .w_rd_i         (w_rd_i),
    .w_rd_value_i   (w_rd_value_i),
    .w_rd_store_i   (w_rd_store_i),
    .lu_issue_i     (lu_issue_i),
    .lu_issue_rd_i  (lu_issue_rd_i),
    .lu_valid_i     (lu_valid_i),
    .lu_rd_i        (lu_rd_i),
    .lu_value_i     (lu_value_i),
    .lu_ready_o     (lu_ready_o),
    .dbg_valid_i    (dbg_valid_i),
    .dbg_rd_i       (dbg_rd_i),
    .dbg_value_i    (dbg_value_i),
    .dbg_ready_o    (dbg_ready_o),
    .d_valid_i      (d_valid_i),
    .d_rs1_i        (d_rs1_i),
    .d_rs2_i        (d_rs2_i),
    .d_rd_i         (d_rd_i),
    .hazard_stall_o (hazard_stall_o),
    .rf_rd_o        (rf_rd_o),
    .rf_rd_value_o  (rf_rd_value_o),
    .rf_rd_store_o  (rf_rd_store_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    w_rd_i = 0; w_rd_value_i = 0; w_rd_store_i = 0;
    lu_issue_i = 0; lu_issue_rd_i = 0;
    lu_valid_i = 0; lu_rd_i = 0; lu_value_i = 0;
    dbg_valid_i = 0; dbg_rd_i = 0; dbg_value_i = 0;
    d_valid_i = 0; d_rs1_i = 0; d_rs2_i = 0; d_rd_i = 0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_i = 1'b0;
    #12;
    n_cmp++; if (rf_rd_store_o !== 1'b0) begin n_err++; $display("FAIL reset_store got %b want 0", rf_rd_store_o); end
    n_cmp++; if (rf_rd_o !== 5'd0) begin n_err++; $display("FAIL reset_rd got %0d want 0", rf_rd_o); end
    n_cmp++; if (rf_rd_value_o !== 32'h0) begin n_err++; $display("FAIL reset_value got %h want 0", rf_rd_value_o); end
    n_cmp++; if (lu_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_lu_ready got %b want 1", lu_ready_o); end
    n_cmp++; if (dbg_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_dbg_ready got %b want 0", dbg_ready_o); end
    n_cmp++; if (hazard_stall_o !== 1'b0) begin n_err++; $display("FAIL reset_hazard got %b want 0", hazard_stall_o); end
    tick();
    rst_i = 1'b1;
    tick();
  endtask

  task automatic test_pipe_priority();
    w_rd_store_i = 1; w_rd_i = 5; w_rd_value_i = 32'hAAAA0000;
    dbg_valid_i = 1; dbg_rd_i = 6; dbg_value_i = 32'h66666666;
    #1;
    n_cmp++; if (dbg_ready_o !== 1'b0) begin n_err++; $display("FAIL pp_dbg_blocked got %b want 0", dbg_ready_o); end
    tick();
    n_cmp++; if ({rf_rd_store_o, rf_rd_o, rf_rd_value_o} !== {1'b1, 5'd5, 32'hAAAA0000}) begin
      n_err++; $display("FAIL pp_pipe_write got st=%b rd=%0d v=%h want st=1 rd=5 v=aaaa0000", rf_rd_store_o, rf_rd_o, rf_rd_value_o); end
    n_cmp++; if (dbg_ready_o !== 1'b0) begin n_err++; $display("FAIL pp_dbg_still_blocked got %b want 0", dbg_ready_o); end
    w_rd_store_i = 0;
    #1;
    n_cmp++; if (dbg_ready_o !== 1'b1) begin n_err++; $display("FAIL pp_dbg_ready got %b want 1", dbg_ready_o); end
    tick();
    dbg_valid_i = 0;
    n_cmp++; if ({rf_rd_store_o, rf_rd_o, rf_rd_value_o} !== {1'b1, 5'd6, 32'h66666666}) begin
      n_err++; $display("FAIL pp_dbg_write got st=%b rd=%0d v=%h want st=1 rd=6 v=66666666", rf_rd_store_o, rf_rd_o, rf_rd_value_o); end
    tick();
    n_cmp++; if ({rf_rd_store_o, rf_rd_o} !== {1'b0, 5'd6}) begin
      n_err++; $display("FAIL pp_idle_hold got st=%b rd=%0d want st=0 rd=6", rf_rd_store_o, rf_rd_o); end
  endtask

  task automatic test_ll_path();
    lu_issue_i = 1; lu_issue_rd_i = 7;
    tick();
    lu_issue_i = 0;
    d_valid_i = 1; d_rs1_i = 7; d_rs2_i = 0; d_rd_i = 0;
    #1;
    n_cmp++; if (hazard_stall_o !== 1'b1) begin n_err++; $display("FAIL ll_stall_rs1 got %b want 1", hazard_stall_o); end
    d_rs1_i = 0; d_rd_i = 7;
    #1;
    n_cmp++; if (hazard_stall_o !== 1'b1) begin n_err++; $display("FAIL ll_stall_rd got %b want 1", hazard_stall_o); end
    d_rs1_i = 3; d_rd_i = 4;
    #1;
    n_cmp++; if (hazard_stall_o !== 1'b0) begin n_err++; $display("FAIL ll_no_stall_other got %b want 0", hazard_stall_o); end
    d_rs1_i = 7; d_rd_i = 0;
    lu_valid_i = 1; lu_rd_i = 7; lu_value_i = 32'h12345678;
    #1;
    n_cmp++; if (lu_ready_o !== 1'b1) begin n_err++; $display("FAIL ll_accept_ready got %b want 1", lu_ready_o); end
    tick();
    lu_valid_i = 0;
    n_cmp++; if ({lu_ready_o, rf_rd_store_o, hazard_stall_o} !== 3'b001) begin
      n_err++; $display("FAIL ll_t1 got ready=%b st=%b hz=%b want ready=0 st=0 hz=1", lu_ready_o, rf_rd_store_o, hazard_stall_o); end
    tick();
    n_cmp++; if ({rf_rd_store_o, rf_rd_o, rf_rd_value_o} !== {1'b1, 5'd7, 32'h12345678}) begin
      n_err++; $display("FAIL ll_t2_write got st=%b rd=%0d v=%h want st=1 rd=7 v=12345678", rf_rd_store_o, rf_rd_o, rf_rd_value_o); end
    n_cmp++; if (hazard_stall_o !== 1'b0) begin n_err++; $display("FAIL ll_t2_stall_drop got %b want 0", hazard_stall_o); end
    d_valid_i = 0; d_rs1_i = 0;
    tick();
  endtask

  task automatic test_round_robin();
    reset_dut();
    lu_valid_i = 1; lu_rd_i = 10; lu_value_i = 32'h10101010;
    tick();
    dbg_valid_i = 1; dbg_rd_i = 11; dbg_value_i = 32'h11111111;
    #1;
    n_cmp++; if (dbg_ready_o !== 1'b0) begin n_err++; $display("FAIL rr_first_buf got dbg_ready=%b want 0", dbg_ready_o); end
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k % 2 == 0) begin
        n_cmp++; if ({rf_rd_store_o, rf_rd_o, rf_rd_value_o} !== {1'b1, 5'd10, 32'h10101010}) begin
          n_err++; $display("FAIL rr_buf_grant k=%0d got st=%b rd=%0d want st=1 rd=10", k, rf_rd_store_o, rf_rd_o); end
        n_cmp++; if (dbg_ready_o !== 1'b1) begin n_err++; $display("FAIL rr_dbg_next k=%0d got %b want 1", k, dbg_ready_o); end
      end else begin
        n_cmp++; if ({rf_rd_store_o, rf_rd_o, rf_rd_value_o} !== {1'b1, 5'd11, 32'h11111111}) begin
          n_err++; $display("FAIL rr_dbg_grant k=%0d got st=%b rd=%0d want st=1 rd=11", k, rf_rd_store_o, rf_rd_o); end
        n_cmp++; if (dbg_ready_o !== 1'b0) begin n_err++; $display("FAIL rr_buf_next k=%0d got %b want 0", k, dbg_ready_o); end
      end
    end
    lu_valid_i = 0; dbg_valid_i = 0;
    tick();
    n_cmp++; if ({rf_rd_store_o, rf_rd_o} !== {1'b1, 5'd10}) begin
      n_err++; $display("FAIL rr_drain got st=%b rd=%0d want st=1 rd=10", rf_rd_store_o, rf_rd_o); end
    tick();
    n_cmp++; if (rf_rd_store_o !== 1'b0) begin n_err++; $display("FAIL rr_quiet got %b want 0", rf_rd_store_o); end
  endtask

  // Pointer favours debug here (last grant went to the buffer).
  task automatic test_backpressure();
    w_rd_store_i = 1; w_rd_i = 2; w_rd_value_i = 32'h22220000;
    lu_valid_i = 1; lu_rd_i = 12; lu_value_i = 32'hC0C00001;
    tick();
    lu_rd_i = 13; lu_value_i = 32'hC0C00002;
    n_cmp++; if (lu_ready_o !== 1'b0) begin n_err++; $display("FAIL bp_full got lu_ready=%b want 0", lu_ready_o); end
    tick();
    n_cmp++; if ({rf_rd_store_o, rf_rd_o} !== {1'b1, 5'd2}) begin
      n_err++; $display("FAIL bp_pipe_write got st=%b rd=%0d want st=1 rd=2", rf_rd_store_o, rf_rd_o); end
    n_cmp++; if (lu_ready_o !== 1'b0) begin n_err++; $display("FAIL bp_still_full got %b want 0", lu_ready_o); end
    w_rd_store_i = 0;
    dbg_valid_i = 1; dbg_rd_i = 14; dbg_value_i = 32'hD0D00000;
    #1;
    n_cmp++; if (dbg_ready_o !== 1'b1) begin n_err++; $display("FAIL bp_rr_dbg_favoured got %b want 1", dbg_ready_o); end
    tick();
    dbg_valid_i = 0;
    n_cmp++; if ({rf_rd_store_o, rf_rd_o, rf_rd_value_o} !== {1'b1, 5'd14, 32'hD0D00000}) begin
      n_err++; $display("FAIL bp_dbg_write got st=%b rd=%0d v=%h want st=1 rd=14 v=d0d00000", rf_rd_store_o, rf_rd_o, rf_rd_value_o); end
    n_cmp++; if (lu_ready_o !== 1'b0) begin n_err++; $display("FAIL bp_grant_cycle_ready got %b want 0", lu_ready_o); end
    tick();
    n_cmp++; if ({rf_rd_store_o, rf_rd_o, rf_rd_value_o} !== {1'b1, 5'd12, 32'hC0C00001}) begin
      n_err++; $display("FAIL bp_first_result got st=%b rd=%0d v=%h want st=1 rd=12 v=c0c00001", rf_rd_store_o, rf_rd_o, rf_rd_value_o); end
    n_cmp++; if (lu_ready_o !== 1'b1) begin n_err++; $display("FAIL bp_accept_after_grant got %b want 1", lu_ready_o); end
    tick();
    lu_valid_i = 0;
    n_cmp++; if (rf_rd_store_o !== 1'b0) begin n_err++; $display("FAIL bp_capture_gap got %b want 0", rf_rd_store_o); end
    tick();
    n_cmp++; if ({rf_rd_store_o, rf_rd_o, rf_rd_value_o} !== {1'b1, 5'd13, 32'hC0C00002}) begin
      n_err++; $display("FAIL bp_second_result got st=%b rd=%0d v=%h want st=1 rd=13 v=c0c00002", rf_rd_store_o, rf_rd_o, rf_rd_value_o); end
    tick();
  endtask

  task automatic test_x0_and_setclear();
    dbg_valid_i = 1; dbg_rd_i = 0; dbg_value_i = 32'hDEAD0000;
    #1;
    n_cmp++; if (dbg_ready_o !== 1'b1) begin n_err++; $display("FAIL x0_dbg_ready got %b want 1", dbg_ready_o); end
    tick();
    dbg_valid_i = 0;
    n_cmp++; if (rf_rd_store_o !== 1'b0) begin n_err++; $display("FAIL x0_no_write got %b want 0", rf_rd_store_o); end
    lu_issue_i = 1; lu_issue_rd_i = 9;
    tick();
    lu_issue_i = 0;
    lu_valid_i = 1; lu_rd_i = 9; lu_value_i = 32'h00009999;
    tick();
    lu_valid_i = 0;
    lu_issue_i = 1; lu_issue_rd_i = 9;
    d_valid_i = 1; d_rs1_i = 0; d_rs2_i = 9; d_rd_i = 0;
    tick();
    lu_issue_i = 0;
    n_cmp++; if ({rf_rd_store_o, rf_rd_o} !== {1'b1, 5'd9}) begin
      n_err++; $display("FAIL sc_write got st=%b rd=%0d want st=1 rd=9", rf_rd_store_o, rf_rd_o); end
    n_cmp++; if (hazard_stall_o !== 1'b1) begin n_err++; $display("FAIL sc_set_wins got %b want 1", hazard_stall_o); end
    lu_valid_i = 1; lu_value_i = 32'h00009A9A;
    tick();
    lu_valid_i = 0;
    tick();
    n_cmp++; if (hazard_stall_o !== 1'b0) begin n_err++; $display("FAIL sc_clear got %b want 0", hazard_stall_o); end
    d_valid_i = 0; d_rs2_i = 0;
    tick();
  endtask

  task automatic test_async_reset();
    lu_issue_i = 1; lu_issue_rd_i = 3;
    tick();
    lu_issue_i = 0;
    w_rd_store_i = 1; w_rd_i = 4; w_rd_value_i = 32'h44444444;
    lu_valid_i = 1; lu_rd_i = 3; lu_value_i = 32'h33333333;
    tick();
    lu_valid_i = 0;
    d_valid_i = 1; d_rs1_i = 3;
    #1;
    n_cmp++; if ({rf_rd_store_o, lu_ready_o, hazard_stall_o} !== 3'b101) begin
      n_err++; $display("FAIL ar_pre got st=%b ready=%b hz=%b want st=1 ready=0 hz=1", rf_rd_store_o, lu_ready_o, hazard_stall_o); end
    #2;
    rst_i = 1'b0;
    w_rd_store_i = 0;
    #1;
    n_cmp++; if ({rf_rd_store_o, rf_rd_o, rf_rd_value_o} !== {1'b0, 5'd0, 32'h0}) begin
      n_err++; $display("FAIL ar_outputs got st=%b rd=%0d v=%h want all 0", rf_rd_store_o, rf_rd_o, rf_rd_value_o); end
    n_cmp++; if ({lu_ready_o, dbg_ready_o, hazard_stall_o} !== 3'b100) begin
      n_err++; $display("FAIL ar_flags got ready=%b dbg=%b hz=%b want 1 0 0", lu_ready_o, dbg_ready_o, hazard_stall_o); end
    tick();
    rst_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if ({rf_rd_store_o, hazard_stall_o} !== 2'b00) begin
        n_err++; $display("FAIL ar_after_release k=%0d got st=%b hz=%b want 0 0", k, rf_rd_store_o, hazard_stall_o); end
    end
    d_valid_i = 0; d_rs1_i = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_pipe_priority();
    test_ll_path();
    test_round_robin();
    test_backpressure();
    test_x0_and_setclear();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
